// File: rtl/serial_logic_pkg.sv
// Shared types and helpers for the serial logic processor register/control slice.
package serial_logic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int count_bits(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_reg_n.sv
// One N-bit operand register with parallel load and serial shift.
// SERIAL_MSB_FIRST_EN selects MSB-first left shift; default is LSB-first right shift.
module shift_reg_n
  import serial_logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Shift_En,
  input  logic [WIDTH-1:0] Din,
  input  logic             Shift_In,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] Data_Out
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_q <= '0;
    end else if (Load) begin
      data_q <= Din;
    end else if (Shift_En) begin
`ifdef SERIAL_MSB_FIRST_EN
      data_q <= {data_q[WIDTH-2:0], Shift_In};
`else
      data_q <= {Shift_In, data_q[WIDTH-1:1]};
`endif
    end
  end

`ifdef SERIAL_MSB_FIRST_EN
  assign Shift_Out = data_q[WIDTH-1];
`else
  assign Shift_Out = data_q[0];
`endif

  assign Data_Out = data_q;

endmodule

// File: rtl/serial_shift_control.sv
// Operand registers A/B plus the IDLE/SHIFT/HOLD sequencer: WIDTH shifts per Execute press.
// Optional build macro SERIAL_MSB_FIRST_EN (handled in shift_reg_n) selects MSB-first shifting.
module serial_shift_control
  import serial_logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Execute,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic [WIDTH-1:0] Din,
  input  logic             A_Ret,
  input  logic             B_Ret,
  output logic             A_Shift_Out,
  output logic             B_Shift_Out,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Dbg_State
);

  localparam int CW = count_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: Execute is a level request sampled in IDLE; Done stays high in HOLD
  // until Execute drops, so each press yields exactly one operation.
  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          load_en_a, load_en_b, shift_en;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (Execute) begin
          state_d = SHIFT;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (count_q == LAST) begin
          state_d = HOLD;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      HOLD: begin
        if (!Execute) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign load_en_a = (state_q == IDLE) && LoadA;
  assign load_en_b = (state_q == IDLE) && LoadB;
  assign shift_en  = (state_q == SHIFT);
  assign Busy      = (state_q == SHIFT);
  assign Done      = (state_q == HOLD);
  assign Dbg_State = state_q;

  shift_reg_n #(.WIDTH(WIDTH)) u_reg_a (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (load_en_a),
    .Shift_En  (shift_en),
    .Din       (Din),
    .Shift_In  (A_Ret),
    .Shift_Out (A_Shift_Out),
    .Data_Out  (Aval)
  );

  shift_reg_n #(.WIDTH(WIDTH)) u_reg_b (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (load_en_b),
    .Shift_En  (shift_en),
    .Din       (Din),
    .Shift_In  (B_Ret),
    .Shift_Out (B_Shift_Out),
    .Data_Out  (Bval)
  );

endmodule

// File: tb/tb_serial_shift_control.sv
// Scoreboard bench for serial_shift_control: directed operations with a combinational return loop.
module tb_serial_shift_control;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         execute;
  logic         load_a;
  logic         load_b;
  logic [W-1:0] din;
  logic         a_ret;
  logic         b_ret;
  logic         a_so;
  logic         b_so;
  logic [W-1:0] aval;
  logic [W-1:0] bval;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int mode;
  int pass_cnt  = 0;
  int total_cnt = 0;
  int busy_cnt  = 0;
  logic done_prev = 1'b0;
  logic [2*W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  serial_shift_control #(.WIDTH(W)) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .Execute     (execute),
    .LoadA       (load_a),
    .LoadB       (load_b),
    .Din         (din),
    .A_Ret       (a_ret),
    .B_Ret       (b_ret),
    .A_Shift_Out (a_so),
    .B_Shift_Out (b_so),
    .Aval        (aval),
    .Bval        (bval),
    .Busy        (busy),
    .Done        (done),
    .Dbg_State   (dbg_state)
  );

  // Return path: 0 identity, 1 swap, 2 AND into B with A unchanged.
  always_comb begin
    a_ret = a_so;
    b_ret = b_so;
    case (mode)
      1: begin a_ret = b_so; b_ret = a_so; end
      2: begin a_ret = a_so; b_ret = a_so & b_so; end
      default: begin a_ret = a_so; b_ret = b_so; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // scoreboard monitor: every rising Done must match the oldest expected result
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !done_prev) begin
        check("busy_cycles", busy_cnt, W);
        busy_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          check("aval", aval, e[2*W-1:W]);
          check("bval", bval, e[W-1:0]);
        end
      end
      done_prev = done;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    load_a = 1'b1; din = a;
    step();
    load_a = 1'b0; load_b = 1'b1; din = b;
    step();
    load_b = 1'b0;
    check("load_a", aval, a);
    check("load_b", bval, b);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb);
    exp_q.push_back({ea, eb});
    execute = 1'b1;
    step();
    execute = 1'b0;
    wait_done(name);
    step();
    check({name, "_idle_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; execute = 1'b0; load_a = 1'b0; load_b = 1'b0; din = '0; mode = 0;
    repeat (2) step();
    check("rst_aval", aval, 0);
    check("rst_bval", bval, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_a_so", a_so, 0);
    check("rst_b_so", b_so, 0);
    rst_n = 1'b1;
    step();

    // identity loop
    mode = 0;
    load_ab(4'b1010, 4'b0110);
    run_op("identity", 4'b1010, 4'b0110);

    // swap loop, two patterns
    mode = 1;
    load_ab(4'b1010, 4'b0110);
    run_op("swap1", 4'b0110, 4'b1010);
    load_ab(4'b1100, 4'b0011);
    run_op("swap2", 4'b0011, 4'b1100);

    // AND into B
    mode = 2;
    load_ab(4'b1010, 4'b0110);
    run_op("and", 4'b1010, 4'b0010);

    // load A on the same edge as Execute: shifting uses the loaded value
    mode = 0;
    load_ab(4'b0000, 4'b0110);
    exp_q.push_back({4'b0101, 4'b0110});
    load_a = 1'b1; din = 4'b0101; execute = 1'b1;
    step();
    load_a = 1'b0; execute = 1'b0;
    wait_done("load_exec");
    step();

    // loads in SHIFT cycle 2 and in HOLD are ignored
    load_ab(4'b1010, 4'b0110);
    exp_q.push_back({4'b1010, 4'b0110});
    execute = 1'b1;
    step();
    execute = 1'b0;
    step();
    step();
    load_a = 1'b1; din = 4'b1111;
    step();
    load_a = 1'b0;
    wait_done("load_shift");
    load_a = 1'b1; din = 4'b1111;
    step();
    load_a = 1'b0;
    check("hold_load_aval", aval, 4'b1010);
    check("hold_load_bval", bval, 4'b0110);

    // Execute held for 20 cycles: one operation, Done held
    exp_q.push_back({4'b1010, 4'b0110});
    execute = 1'b1;
    repeat (20) step();
    check("held_done", done, 1);
    check("held_busy", busy, 0);
    execute = 1'b0;
    step();
    check("release_done", done, 0);
    check("release_state", dbg_state, 2'd0);
    run_op("repress", 4'b1010, 4'b0110);

    // asynchronous reset during SHIFT count==2
    load_ab(4'b1001, 4'b0111);
    execute = 1'b1;
    step();
    execute = 1'b0;
    step();
    step();
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_aval", aval, 0);
    check("mid_rst_bval", bval, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_state", dbg_state, 2'd0);
    step();
    rst_n = 1'b1;
    step();
    mode = 1;
    load_ab(4'b1100, 4'b0011);
    run_op("post_rst", 4'b0011, 4'b1100);

    repeat (2) step();
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_shift_control.md
Name: serial_shift_control

Overview:
- Register-and-control half of the serial logic processor.
- Holds the two N-bit operand registers A and B and presents their serial bits (A_Shift_Out, B_Shift_Out) to the bit-function and routing stage.
- Captures the routed return bits (A_Ret, B_Ret) back into A and B.
- Sequences exactly WIDTH shift cycles per Execute press, then holds until Execute is released.

Parameters:
WIDTH, 4, operand register width; also the number of shift cycles per operation (legal range 2..16).

Ports:
Clk  in  1  system clock; all state changes on the rising edge.
Reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
Execute  in  1  level request to run one serial operation; synchronous, sampled on Clk.
LoadA  in  1  load Din into A; honoured only in IDLE.
LoadB  in  1  load Din into B; honoured only in IDLE.
Din  in  WIDTH  parallel load data.
A_Ret  in  1  routed return bit for A (from the router's A output).
B_Ret  in  1  routed return bit for B (from the router's B output).
A_Shift_Out  out  1  current serial bit of A, feeding the function/router A input.
B_Shift_Out  out  1  current serial bit of B, feeding the function/router B input.
Aval  out  WIDTH  current contents of A.
Bval  out  WIDTH  current contents of B.
Busy  out  1  high while in SHIFT.
Done  out  1  high while in HOLD.

Behaviour:
- Reset (Reset=0, asynchronous):
  - A=0, B=0, state=IDLE, count=0.
  - Busy=0, Done=0, A_Shift_Out=0, B_Shift_Out=0.
  - Applies mid-operation too: the partial result is discarded.
- Serial outputs are combinational from register bits: A_Shift_Out=A[0], B_Shift_Out=B[0] (default LSB-first).
- IDLE:
  - LoadA=1 → A<=Din; LoadB=1 → B<=Din. Both may load in the same cycle.
  - Execute=1 → SHIFT, count<=0. A same-cycle load still takes effect, so shifting uses the loaded values.
- SHIFT, on every edge:
  - A<={A_Ret, A[WIDTH-1:1]}, B<={B_Ret, B[WIDTH-1:1]}, count<=count+1.
  - On the edge where count==WIDTH-1: perform the final shift, go to HOLD, count<=0.
  - Exactly WIDTH shifts. Loads are ignored. Execute is don't-care.
- HOLD:
  - Registers frozen.
  - Execute=0 → IDLE. Execute=1 → stay in HOLD; one operation per press, no auto-repeat.
  - Loads ignored.
- Latency: Execute sampled at edge 0 → shifts at edges 1..WIDTH → Done=1 after edge WIDTH. Minimum time from one Execute to the next is WIDTH+2 cycles.
- Return bits are sampled on the same edge as the shift. The external function/router path must be purely combinational from A_Shift_Out/B_Shift_Out to A_Ret/B_Ret.
- Counter is $clog2(WIDTH) bits and never wraps past WIDTH-1.
- An illegal or unused state encoding recovers to IDLE on the next edge.

Optional Feature:
SERIAL_MSB_FIRST_EN.
- Defined:
  - A_Shift_Out=A[WIDTH-1], B_Shift_Out=B[WIDTH-1].
  - Shift left: A<={A[WIDTH-2:0], A_Ret}, and likewise for B.
- Undefined: LSB-first right shift as above.
- Cycle count, handshake and reset behaviour are identical in both builds.

Decomposition:
- Package serial_logic_pkg:
  - state_t enum {IDLE, SHIFT, HOLD}.
  - Localparam DEFAULT_WIDTH=4.
  - Function count_bits(width) returning $clog2(width).
- Sub-module shift_reg_n:
  - Parameterised by WIDTH.
  - Ports: Clk, Reset, Load, Shift_En, Din, Shift_In; outputs Shift_Out, Data_Out.
  - Contains the SERIAL_MSB_FIRST_EN handling.
  - Instantiated twice, for A and B.
- serial_shift_control itself keeps the FSM and the counter.

Test Plan:
- Identity loop: WIDTH=4, bench returns A_Ret=A_Shift_Out, B_Ret=B_Shift_Out. Load A=1010 and B=0110, then pulse Execute → Busy high exactly 4 cycles; then Done=1, Aval=1010, Bval=0110.
- Swap loop: A_Ret=B_Shift_Out, B_Ret=A_Shift_Out, same loads → Aval=0110, Bval=1010 after Done.
- AND into B, A unchanged: A_Ret=A_Shift_Out, B_Ret=A_Shift_Out&B_Shift_Out, with A=1010, B=0110 → Aval=1010, Bval=0010.
- Loads during SHIFT/HOLD: assert LoadA with Din=1111 in SHIFT cycle 2 and in HOLD → ignored, results identical to the identity-loop case.
- Execute held high for 20 cycles → exactly one 4-cycle operation and Done held. Release Execute → IDLE next edge. Re-press → a second operation runs.
- Reset mid-operation: Reset=0 during SHIFT count=2, asynchronously between edges → Aval=Bval=0000, Busy=0, Done=0 immediately. After release, a fresh load and Execute behave normally.
